// File: rtl/mem_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_requester_if
// Description : Bundles the command, response and memory-strobe signals of
//               the 256-bit word memory requester.
//               master : the requester (drives reqReady, rsp*, busy, mem*)
//               slave  : command source / response sink / memory responder
//               Command : reqValid, reqReady, reqRW, reqAddr, reqLen, reqData
//               Response: rspValid, rspRW, rspData, busy
//               Memory  : memAddr, memRW, memWrite, memDo, memBus
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_requester_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256
);
    logic              reqValid;
    logic              reqReady;
    logic              reqRW;
    logic [ADDR_W-1:0] reqAddr;
    logic [3:0]        reqLen;
    logic [DATA_W-1:0] reqData;
    logic              rspValid;
    logic              rspRW;
    logic [DATA_W-1:0] rspData;
    logic              busy;
    logic [ADDR_W-1:0] memAddr;
    logic              memRW;
    logic [DATA_W-1:0] memWrite;
    logic              memDo;
    logic [DATA_W-1:0] memBus;

    modport master (
        input  reqValid, reqRW, reqAddr, reqLen, reqData, memBus,
        output reqReady, rspValid, rspRW, rspData, busy,
               memAddr, memRW, memWrite, memDo
    );

    modport slave (
        output reqValid, reqRW, reqAddr, reqLen, reqData, memBus,
        input  reqReady, rspValid, rspRW, rspData, busy,
               memAddr, memRW, memWrite, memDo
    );
endinterface
`default_nettype wire

// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : mem_requester
// Description : Initiator of the strobe-based word memory interface. Accepts
//               single-word writes and 1..8 beat address-incrementing read
//               bursts, sequences memAddr/memRW/memWrite/memDo toward the
//               responder and returns each beat on a one-cycle rspValid.
//               Ports: clk, nReset (async active-low), bus (master modport
//               of mem_requester_if carrying command, response and memory
//               signals).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_requester #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8
) (
    input  wire logic       clk,
    input  wire logic       nReset,
    mem_requester_if.master bus
);

    localparam logic [ADDR_W-1:0] c_depth    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_lastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              w_accept;
    logic              w_moreBeats;
    logic [3:0]        w_len;
    logic [3:0]        r_beats;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_memRW;
    logic [DATA_W-1:0] r_memWrite;
    logic              r_memDo;
    logic              r_rspValid;
    logic              r_rspRW;
    logic [DATA_W-1:0] r_rspData;

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and command-accept decode
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_moreBeats = (r_beats > 4'd1);
        // Length 0 means one beat; anything above 8 is clamped to 8
        w_len = bus.reqLen;
        if (bus.reqLen == 4'd0) begin
            w_len = 4'd1;
        end else if (bus.reqLen > 4'd8) begin
            w_len = 4'd8;
        end
        case (r_state)
            S_IDLE: begin
                if (bus.reqValid) begin
                    w_accept    = 1'b1;
                    w_nextState = S_SETUP;
                end
            end
            S_SETUP:   w_nextState = S_STROBE;
            S_STROBE:  w_nextState = S_CAPTURE;
            S_CAPTURE: w_nextState = w_moreBeats ? S_SETUP : S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Datapath. Address/direction/write data are only updated on the edges
    // that enter SETUP (accept, or CAPTURE with beats left), so they are
    // guaranteed stable across the whole memDo pulse.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_beats    <= 4'd0;
            r_memAddr  <= '0;
            r_memRW    <= 1'b1;
            r_memWrite <= '0;
            r_memDo    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspRW    <= 1'b1;
            r_rspData  <= '0;
        end else begin
            r_rspValid <= 1'b0;
            // Registered strobe: high exactly for the STROBE state
            r_memDo    <= (w_nextState == S_STROBE);
            if (w_accept) begin
                r_memAddr  <= bus.reqAddr % c_depth;
                r_memRW    <= bus.reqRW;
                r_memWrite <= bus.reqData;
                r_beats    <= bus.reqRW ? w_len : 4'd1;
            end
            if (r_state == S_CAPTURE) begin
                r_rspValid <= 1'b1;
                r_rspRW    <= r_memRW;
                if (r_memRW) begin
                    r_rspData <= bus.memBus;
                end
                r_beats <= r_beats - 4'd1;
                if (w_moreBeats) begin
                    r_memAddr <= (r_memAddr == c_lastAddr) ? '0
                                                           : r_memAddr + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.reqReady = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.memAddr  = r_memAddr;
    assign bus.memRW    = r_memRW;
    assign bus.memWrite = r_memWrite;
    assign bus.memDo    = r_memDo;
    assign bus.rspValid = r_rspValid;
    assign bus.rspRW    = r_rspRW;
    assign bus.rspData  = r_rspData;

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_requester
// Description : Self-checking bench for mem_requester. A timeline model
//               predicts, from each accepted command, the cycles of every
//               memDo strobe and rspValid pulse plus the busy window; a
//               compare process checks the DUT against it every cycle.
//               Directed tests add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_requester;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {int cyc; logic rw; word_t data;} rsp_t;
    typedef struct {int cyc; logic [ADDR_W-1:0] addr; logic rw; word_t data;} strobe_t;

    logic clk    = 1'b0;
    logic nReset = 1'b0;

    mem_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: acts on the rising edge of memDo
    word_t tbMem [DEPTH];
    always @(posedge bus.memDo) begin
        if (!bus.memRW) tbMem[int'(bus.memAddr) % DEPTH] <= bus.memWrite;
        else            bus.memBus <= tbMem[int'(bus.memAddr) % DEPTH];
    end

    // Model state
    int      cyc        = 0;
    int      checks     = 0;
    int      errors     = 0;
    int      busyUntil  = -1;
    int      acceptCnt  = 0;
    int      lastAccept = 0;
    int      rspCount   = 0;
    word_t   lastRead   = '0;
    word_t   modelMem [DEPTH];
    rsp_t    rspQ [$];
    strobe_t doQ [$];
    int      logCyc [$];
    word_t   logData [$];

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process + timeline model
    always @(negedge clk) begin : cmpBlk
        logic expRsp, expDo, expBusy;
        int   n, a0, a;
        cyc++;
        if (!nReset) begin
            rspQ.delete();
            doQ.delete();
            busyUntil = -1;
            lastRead  = '0;
            check("rst_memDo",    bus.memDo,    0);
            check("rst_memRW",    bus.memRW,    1);
            check("rst_memAddr",  bus.memAddr,  0);
            check("rst_memWrite", bus.memWrite, 0);
            check("rst_rspValid", bus.rspValid, 0);
            check("rst_rspRW",    bus.rspRW,    1);
            check("rst_rspData",  bus.rspData,  0);
            check("rst_busy",     bus.busy,     0);
        end else begin
            expRsp = (rspQ.size() > 0) && (rspQ[0].cyc == cyc);
            check("rspValid", bus.rspValid, expRsp);
            if (bus.rspValid) begin
                rspCount++;
                logCyc.push_back(cyc);
                logData.push_back(bus.rspData);
            end
            if (expRsp) begin
                check("rspRW",   bus.rspRW,   rspQ[0].rw);
                check("rspData", bus.rspData, rspQ[0].data);
                void'(rspQ.pop_front());
            end

            expDo = (doQ.size() > 0) && (doQ[0].cyc == cyc);
            check("memDo", bus.memDo, expDo);
            if (expDo) begin
                check("memAddr", bus.memAddr, doQ[0].addr);
                check("memRW",   bus.memRW,   doQ[0].rw);
                if (!doQ[0].rw) check("memWrite", bus.memWrite, doQ[0].data);
                void'(doQ.pop_front());
            end

            expBusy = (cyc <= busyUntil);
            check("busy",     bus.busy,     expBusy);
            check("reqReady", bus.reqReady, !expBusy);

            if (bus.reqValid && bus.reqReady) begin
                a0 = int'(bus.reqAddr) % DEPTH;
                if (!bus.reqRW)               n = 1;
                else if (bus.reqLen == 4'd0)  n = 1;
                else if (bus.reqLen > 4'd8)   n = 8;
                else                          n = int'(bus.reqLen);
                for (int i = 0; i < n; i++) begin
                    a = (a0 + i) % DEPTH;
                    if (bus.reqRW) begin
                        doQ.push_back('{cyc + 2 + 3*i, ADDR_W'(a), 1'b1, '0});
                        lastRead = modelMem[a];
                        rspQ.push_back('{cyc + 4 + 3*i, 1'b1, modelMem[a]});
                    end else begin
                        doQ.push_back('{cyc + 2, ADDR_W'(a), 1'b0, bus.reqData});
                        modelMem[a] = bus.reqData;
                        rspQ.push_back('{cyc + 4, 1'b0, lastRead});
                    end
                end
                busyUntil  = cyc + 3*n;
                acceptCnt++;
                lastAccept = cyc;
            end
        end
    end

    // Stimulus helpers (called just after a rising edge)
    task automatic sendCmd(input logic rw, input int addr, input int len, input word_t data);
        bit got;
        got = 0;
        bus.reqRW    = rw;
        bus.reqAddr  = addr[ADDR_W-1:0];
        bus.reqLen   = len[3:0];
        bus.reqData  = data;
        bus.reqValid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.reqReady) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no reqReady required reqReady within 200 cycles");
        end
        @(posedge clk);
        #2;
        bus.reqValid = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1;
                break;
            end
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL idle_timeout: got busy required idle within 200 cycles");
        end
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int    a1, a2, cnt0, r0;
        word_t expD [4];
        int    expO [4];
        expD = '{256'd6, 256'd7, 256'd0, 256'd1};
        expO = '{4, 7, 10, 13};
        for (int i = 0; i < DEPTH; i++) begin
            tbMem[i]    = '0;
            modelMem[i] = '0;
        end
        bus.reqValid = 1'b0;
        bus.reqRW    = 1'b0;
        bus.reqAddr  = '0;
        bus.reqLen   = '0;
        bus.reqData  = '0;
        repeat (3) @(posedge clk);
        #2;
        nReset = 1'b1;
        @(posedge clk);
        #2;

        // 1: single write, latency literals
        sendCmd(1'b0, 3, 1, {32{8'hA5}});
        @(negedge clk); check("t1_memDo_c1", bus.memDo, 0);
        @(negedge clk); check("t1_memDo_c2", bus.memDo, 1);
        check("t1_memAddr", bus.memAddr, 3);
        check("t1_memRW",   bus.memRW,   0);
        @(negedge clk);
        @(negedge clk); check("t1_rspValid_c4", bus.rspValid, 1);
        check("t1_rspRW", bus.rspRW, 0);
        waitIdle();

        // 2: write then read back
        sendCmd(1'b0, 5, 1, 256'h1234);
        waitIdle();
        sendCmd(1'b1, 5, 1, '0);
        repeat (4) @(negedge clk);
        check("t2_rspValid_c4", bus.rspValid, 1);
        check("t2_rspRW",       bus.rspRW,    1);
        check("t2_rspData",     bus.rspData,  256'h1234);
        waitIdle();

        // 3: preload value=index, wrapping 4-beat burst from 6
        for (int i = 0; i < DEPTH; i++) begin
            sendCmd(1'b0, i, 1, word_t'(i));
            waitIdle();
        end
        logCyc.delete();
        logData.delete();
        sendCmd(1'b1, 6, 4, '0);
        waitIdle();
        check("t3_beats", logData.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < logData.size()) begin
                check("t3_data",   logData[i], expD[i]);
                check("t3_offset", logCyc[i] - lastAccept + 0, expO[i]);
            end
        end

        // 4: command held during a 4-beat burst
        cnt0 = acceptCnt;
        sendCmd(1'b1, 0, 4, '0);
        a1 = lastAccept;
        sendCmd(1'b1, 2, 1, '0);
        a2 = lastAccept;
        check("t4_accept_gap", a2 - a1, 13);
        waitIdle();
        check("t4_accepts", acceptCnt - cnt0, 2);

        // 5: reset while memDo is high
        sendCmd(1'b1, 1, 4, '0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.memDo) break;
        end
        #1;
        nReset = 1'b0;
        r0 = rspCount;
        #1;
        check("t5_memDo",    bus.memDo,    0);
        check("t5_busy",     bus.busy,     0);
        check("t5_memRW",    bus.memRW,    1);
        check("t5_rspValid", bus.rspValid, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        nReset = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("t5_no_rsp", rspCount - r0, 0);

        // 6: length 0 and length 12, plus wrapped write address
        r0 = rspCount;
        sendCmd(1'b1, 0, 0, '0);
        waitIdle();
        check("t6_len0", rspCount - r0, 1);
        r0 = rspCount;
        sendCmd(1'b1, 2, 12, '0);
        waitIdle();
        check("t6_len12", rspCount - r0, 8);
        sendCmd(1'b0, 13, 1, 256'hBEEF);
        waitIdle();
        sendCmd(1'b1, 5, 1, '0);
        waitIdle();
        check("t6_wrap_write", bus.rspData, 256'hBEEF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
